branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Control-side counterpart of the CON flip-flop: sequences conditional-branch instructions (brzr, brnz, brpl, brmi).
- Drives the CON evaluation enable and C2 select, samples the resulting condition bit, then runs the PC + sign-extended C address computation. PC is written only when the condition held.
- Sits between the instruction decoder and the datapath control lines. Keeps saturating taken/not-taken counters for debug.

Parameters:
- SKIP_NOT_TAKEN, 0, 1 = return to IDLE straight after evaluation when the condition is false (skip T4–T6).
- CNT_W, 16, width of the taken and not-taken statistic counters.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to execute the branch held in ir; accepted only in IDLE.
- ir  in  32  instruction word: opcode [31:27], Ra [26:23], C2 [20:19], C [18:0].
- con_out  in  1  condition result from the CON flip-flop.
- gra  out  1  select Ra for the register-file read.
- r_out  out  1  register-file drive onto the bus.
- con_in  out  1  CON evaluation enable.
- con_c2  out  2  latched C2 field presented to the CON decoder.
- pc_out  out  1  PC drive onto the bus.
- y_in  out  1  Y register load.
- c_out  out  1  sign-extended C drive onto the bus.
- alu_add  out  1  ALU operation = ADD.
- z_in  out  1  Z register load.
- z_lo_out  out  1  Z low word drive onto the bus.
- pc_in  out  1  PC load.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle completion pulse.
- taken  out  1  registered condition result of the last branch.
- taken_cnt  out  CNT_W  saturating count of taken branches.
- ntaken_cnt  out  CNT_W  saturating count of not-taken branches.

Behaviour:
- Reset (clear=0, async): state=IDLE. All outputs are 0, including con_c2, taken and both counters. Reset mid-sequence aborts immediately; pc_in is never asserted afterwards for that branch.
- States: IDLE, EVAL, T4, T5, T6, FIN.
- IDLE:
  - start=1 latches ir[20:19] into con_c2 and ir[18:0] into the internal C register (sign-extended to 32 bits on c_out use).
  - Next state = EVAL. start=0: stay in IDLE.
- EVAL: gra=r_out=con_in=1. At the closing edge:
  - taken <= con_out.
  - Increment taken_cnt or ntaken_cnt.
  - If SKIP_NOT_TAKEN=1 and con_out=0: next = FIN. Otherwise next = T4.
- T4: pc_out=y_in=1.
- T5: c_out=alu_add=z_in=1.
- T6: z_lo_out=1; pc_in=taken (registered value, not the live con_out).
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency from start to done: 5 cycles (taken, or SKIP_NOT_TAKEN=0); 2 cycles (not taken with SKIP_NOT_TAKEN=1).
- Control outputs are decoded from the registered state. Strobes are mutually exclusive per state as listed; every unlisted strobe is 0.
- start while busy=1 is ignored. No queueing.
- con_c2 holds its value from acceptance until the next accepted start.
- Counters saturate at all-ones, with no wrap. Increments happen only in EVAL.
- ir changes after acceptance have no effect.
- The opcode field is not checked; the decoder only issues start for branch opcodes.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - State enum encoding.
  - Field constants: C2_LO=19, C2_HI=20, C_HI=18.
  - C2 codes: BR_ZR=2'b00, BR_NZ=2'b01, BR_PL=2'b10, BR_MI=2'b11.
- Sub-module sat_counter (CNT_W width, inc enable, async active-low clear), instantiated twice for the statistic counters.
- FSM and strobe decode stay in branch_sequencer.

Test Plan:
- Taken path: reset, then start with ir C2=00 and C=0x00010; con_out=1 during EVAL -> strobes in order EVAL/T4/T5/T6; pc_in=1 in T6; done 5 cycles after start; taken=1; taken_cnt=1.
- Not taken, SKIP_NOT_TAKEN=0: C2=01, con_out=0 -> full T4–T6 sequence with pc_in=0; done at cycle 5; ntaken_cnt=1.
- Not taken, SKIP_NOT_TAKEN=1: con_out=0 -> EVAL then FIN; done 2 cycles after start; no pc_out, y_in or pc_in pulse.
- Condition sampling: con_out toggles 1->0 after the EVAL edge -> pc_in in T6 still follows the sampled value 1; con_c2 equals the latched ir[20:19]=2'b11 throughout.
- Start while busy: second start pulse in T5 -> ignored; exactly one done pulse; counters change by 1.
- Reset and saturation:
  - Assert clear in T5 -> all outputs 0 immediately, no pc_in afterwards, counters 0.
  - With CNT_W=2, run 5 taken branches -> taken_cnt stays at 3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Shared control-unit types and instruction field positions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EVAL = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    localparam int C2_LO = 19;
    localparam int C2_HI = 20;
    localparam int C_HI  = 18;

    localparam logic [1:0] BR_ZR = 2'b00;
    localparam logic [1:0] BR_NZ = 2'b01;
    localparam logic [1:0] BR_PL = 2'b10;
    localparam logic [1:0] BR_MI = 2'b11;

    function automatic logic [31:0] sext_c(input logic [C_HI:0] c);
        return {{(31 - C_HI){c[C_HI]}}, c};
    endfunction

endpackage : cpu_ctrl_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/branch_sequencer.sv
// ============================================================================
// Module  : branch_sequencer
// Brief   : Control sequencer for conditional branches (CON evaluate, PC+C).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit SKIP_NOT_TAKEN = 1'b0,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             con_out,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic [1:0]       con_c2,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             alu_add,
    output logic             z_in,
    output logic             z_lo_out,
    output logic             pc_in,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    state_e        state_q, state_d;
    logic [1:0]    con_c2_q, con_c2_d;
    logic [C_HI:0] c_q, c_d;
    logic          taken_q, taken_d;
    logic          taken_inc, ntaken_inc;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            con_c2_q <= 2'b00;
            c_q      <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            con_c2_q <= con_c2_d;
            c_q      <= c_d;
            taken_q  <= taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        con_c2_d   = con_c2_q;
        c_d        = c_q;
        taken_d    = taken_q;
        taken_inc  = 1'b0;
        ntaken_inc = 1'b0;
        gra        = 1'b0;
        r_out      = 1'b0;
        con_in     = 1'b0;
        pc_out     = 1'b0;
        y_in       = 1'b0;
        c_out      = 1'b0;
        alu_add    = 1'b0;
        z_in       = 1'b0;
        z_lo_out   = 1'b0;
        pc_in      = 1'b0;
        done       = 1'b0;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    con_c2_d = ir[C2_HI:C2_LO];
                    c_d      = ir[C_HI:0];
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                gra        = 1'b1;
                r_out      = 1'b1;
                con_in     = 1'b1;
                taken_d    = con_out;
                taken_inc  = con_out;
                ntaken_inc = !con_out;
                state_d    = (SKIP_NOT_TAKEN && !con_out) ? ST_FIN : ST_T4;
            end
            ST_T4: begin
                pc_out  = 1'b1;
                y_in    = 1'b1;
                state_d = ST_T5;
            end
            ST_T5: begin
                c_out   = 1'b1;
                alu_add = 1'b1;
                z_in    = 1'b1;
                state_d = ST_T6;
            end
            ST_T6: begin
                z_lo_out = 1'b1;
                // Uses the condition captured at EVAL; con_out may have moved on.
                pc_in    = taken_q;
                state_d  = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign con_c2 = con_c2_q;
    assign taken  = taken_q;

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (taken_inc),
        .count (taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ntaken_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (ntaken_inc),
        .count (ntaken_cnt)
    );

    // The sign-extended C value is consumed by the datapath's bus driver, not here.
    logic [31:0] c_ext;
    logic        unused_bits;
    assign c_ext       = sext_c(c_q);
    assign unused_bits = ^{ir[31:21], c_ext};

endmodule : branch_sequencer

`default_nettype wire
